// File: rtl/cgra_column_bus_arbiter.sv
// Round-robin arbiter merging N_COLS column OBI master ports onto one OBI master port.
// Keeps the selection locked while the downstream stalls and routes responses back to the
// originating column through an in-order FIFO of granted column indices.
module cgra_column_bus_arbiter #(
  parameter int unsigned N_COLS    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // Column side
  input  logic [N_COLS-1:0]          col_req_i,
  output logic [N_COLS-1:0]          col_gnt_o,
  input  logic [N_COLS*ADDR_W-1:0]   col_addr_i,
  input  logic [N_COLS-1:0]          col_we_i,
  input  logic [N_COLS*DATA_W/8-1:0] col_be_i,
  input  logic [N_COLS*DATA_W-1:0]   col_wdata_i,
  output logic [N_COLS-1:0]          col_rvalid_o,
  output logic [DATA_W-1:0]          col_rdata_o,
  // Crossbar side
  output logic                       bus_req_o,
  output logic [ADDR_W-1:0]          bus_addr_o,
  output logic                       bus_we_o,
  output logic [DATA_W/8-1:0]        bus_be_o,
  output logic [DATA_W-1:0]          bus_wdata_o,
  input  logic                       bus_gnt_i,
  input  logic                       bus_rvalid_i,
  input  logic [DATA_W-1:0]          bus_rdata_i,
  output logic                       err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(N_COLS);
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTST];

  logic [IDX_W-1:0] sel_scan;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             not_full;
  logic             issue;
  logic             push;
  logic             pop;

  // First requesting column at or above rr_ptr, wrapping modulo N_COLS
  always_comb begin
    sel_scan = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N_COLS; k++) begin
      if (!found && col_req_i[(32'(rr_ptr_q) + k) % N_COLS]) begin
        found    = 1'b1;
        sel_scan = IDX_W'((32'(rr_ptr_q) + k) % N_COLS);
      end
    end
  end

  // Selection, issue and handshake qualifiers
  always_comb begin
    sel      = locked_q ? lock_idx_q : sel_scan;
    not_full = (cnt_q < CNT_W'(MAX_OUTST));
    // locked keeps the request alive even if the column illegally withdraws it
    issue    = ((|col_req_i) | locked_q) & not_full & ~rst_i;
    push     = issue & bus_gnt_i;
    pop      = bus_rvalid_i & (cnt_q != '0) & ~rst_i;
  end

  // Merged request payload, zeroed whenever no request is issued
  always_comb begin
    bus_req_o   = issue;
    bus_addr_o  = '0;
    bus_we_o    = 1'b0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    if (issue) begin
      bus_addr_o  = col_addr_i[32'(sel)*ADDR_W +: ADDR_W];
      bus_we_o    = col_we_i[sel];
      bus_be_o    = col_be_i[32'(sel)*BE_W +: BE_W];
      bus_wdata_o = col_wdata_i[32'(sel)*DATA_W +: DATA_W];
    end
  end

  // Column grant and response routing
  always_comb begin
    col_gnt_o    = '0;
    col_rvalid_o = '0;
    if (push) col_gnt_o[sel] = 1'b1;
    if (pop)  col_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    col_rdata_o  = rst_i ? '0 : bus_rdata_i;
    err_o        = err_q & ~rst_i;
  end

  // Next-state for arbitration, lock, FIFO pointers, count and error
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (bus_rvalid_i & (cnt_q == '0));

    if (push) begin
      rr_ptr_d = (sel == IDX_W'(N_COLS - 1)) ? '0 : sel + IDX_W'(1);
      locked_d = 1'b0;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end else if (issue) begin
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are only read behind valid pointers so need no reset
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_cgra_column_bus_arbiter.sv
// Directed bench for cgra_column_bus_arbiter: reset, single access, round robin, lock,
// withdrawn request, outstanding limit, reset mid-operation and spurious response.
module tb_cgra_column_bus_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      col_req = '0;
  logic [N-1:0]      col_gnt;
  logic [N*AW-1:0]   col_addr;
  logic [N-1:0]      col_we;
  logic [N*DW/8-1:0] col_be;
  logic [N*DW-1:0]   col_wdata;
  logic [N-1:0]      col_rvalid;
  logic [DW-1:0]     col_rdata;
  logic              bus_req;
  logic [AW-1:0]     bus_addr;
  logic              bus_we;
  logic [DW/8-1:0]   bus_be;
  logic [DW-1:0]     bus_wdata;
  logic              bus_gnt = 1'b0;
  logic              bus_rvalid = 1'b0;
  logic [DW-1:0]     bus_rdata = '0;
  logic              err;

  int checks = 0;
  int errors = 0;

  cgra_column_bus_arbiter #(
    .N_COLS    (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_OUTST (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .col_req_i    (col_req),
    .col_gnt_o    (col_gnt),
    .col_addr_i   (col_addr),
    .col_we_i     (col_we),
    .col_be_i     (col_be),
    .col_wdata_i  (col_wdata),
    .col_rvalid_o (col_rvalid),
    .col_rdata_o  (col_rdata),
    .bus_req_o    (bus_req),
    .bus_addr_o   (bus_addr),
    .bus_we_o     (bus_we),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then let combinational outputs settle
  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rd);
    col_req    = req;
    bus_gnt    = gnt;
    bus_rvalid = rv;
    bus_rdata  = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Column i: addr (i<<28)|0x40, we = i[0], be = one-hot i, wdata 0xA0+i
    for (int i = 0; i < N; i++) begin
      col_addr[i*AW +: AW]    = (32'(i) << 28) | 32'h40;
      col_we[i]               = 1'(i % 2);
      col_be[i*4 +: 4]        = 4'b0001 << i;
      col_wdata[i*DW +: DW]   = 32'hA0 + 32'(i);
    end

    // Reset: outputs held at zero even with requests and grant present
    drive(4'hF, 1'b1, 1'b1, 32'h1234);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_col_gnt", 64'(col_gnt), 64'd0);
    chk("rst_rvalid", 64'(col_rvalid), 64'd0);
    chk("rst_rdata", 64'(col_rdata), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single request from column 2
    drive(4'b0100, 1'b1, 1'b0, '0);
    chk("single_gnt", 64'(col_gnt), 64'b0100);
    chk("single_addr", 64'(bus_addr), 64'h2000_0040);
    chk("single_we", 64'(bus_we), 64'd0);
    chk("single_be", 64'(bus_be), 64'b0100);
    chk("single_wdata", 64'(bus_wdata), 64'hA2);
    tick();
    drive(4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("single_rvalid", 64'(col_rvalid), 64'b0100);
    chk("single_rdata", 64'(col_rdata), 64'hDEAD_BEEF);
    chk("single_idle_req", 64'(bus_req), 64'd0);
    chk("single_idle_addr", 64'(bus_addr), 64'd0);
    chk("single_err", 64'(err), 64'd0);
    tick();

    // Return rr_ptr to 0 before the round-robin sequence
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;

    // Round robin: all request, grant order 0,1,2,3,0 with responses one cycle behind
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("rr_gnt0", 64'(col_gnt), 64'b0001);
    tick();
    drive(4'hF, 1'b1, 1'b1, 32'h11);
    chk("rr_gnt1", 64'(col_gnt), 64'b0010);
    chk("rr_rv0", 64'(col_rvalid), 64'b0001);
    tick();
    drive(4'hF, 1'b1, 1'b1, 32'h22);
    chk("rr_gnt2", 64'(col_gnt), 64'b0100);
    chk("rr_rv1", 64'(col_rvalid), 64'b0010);
    tick();
    drive(4'hF, 1'b1, 1'b1, 32'h33);
    chk("rr_gnt3", 64'(col_gnt), 64'b1000);
    chk("rr_rv2", 64'(col_rvalid), 64'b0100);
    chk("rr_addr3", 64'(bus_addr), 64'h3000_0040);
    tick();
    drive(4'hF, 1'b1, 1'b1, 32'h44);
    chk("rr_gnt4", 64'(col_gnt), 64'b0001);
    chk("rr_rv3", 64'(col_rvalid), 64'b1000);
    tick();
    drive(4'h0, 1'b1, 1'b1, 32'h55);
    chk("rr_rv4", 64'(col_rvalid), 64'b0001);
    chk("rr_idle_req", 64'(bus_req), 64'd0);
    tick();

    // Column 3 access moves rr_ptr to 0 so column 0 would win when unlocked
    drive(4'b1000, 1'b1, 1'b0, '0);
    chk("pre_lock_gnt", 64'(col_gnt), 64'b1000);
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    chk("pre_lock_rv", 64'(col_rvalid), 64'b1000);
    tick();

    // Lock: column 2 stalled 3 cycles, column 0 arrives meanwhile
    drive(4'b0100, 1'b0, 1'b0, '0);
    chk("lock_c0_addr", 64'(bus_addr), 64'h2000_0040);
    chk("lock_c0_gnt", 64'(col_gnt), 64'd0);
    tick();
    drive(4'b0101, 1'b0, 1'b0, '0);
    chk("lock_c1_addr", 64'(bus_addr), 64'h2000_0040);
    tick();
    drive(4'b0101, 1'b0, 1'b0, '0);
    chk("lock_c2_addr", 64'(bus_addr), 64'h2000_0040);
    chk("lock_c2_req", 64'(bus_req), 64'd1);
    tick();
    drive(4'b0101, 1'b1, 1'b0, '0);
    chk("lock_c3_gnt", 64'(col_gnt), 64'b0100);
    tick();
    drive(4'b0001, 1'b1, 1'b0, '0);
    chk("lock_c4_gnt", 64'(col_gnt), 64'b0001);
    chk("lock_c4_addr", 64'(bus_addr), 64'h0000_0040);
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    chk("lock_rv2", 64'(col_rvalid), 64'b0100);
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    chk("lock_rv0", 64'(col_rvalid), 64'b0001);
    tick();

    // Withdrawn request while locked: request persists with latched column 1
    drive(4'b0010, 1'b0, 1'b0, '0);
    chk("wd_addr0", 64'(bus_addr), 64'h1000_0040);
    tick();
    drive(4'b0000, 1'b0, 1'b0, '0);
    chk("wd_req", 64'(bus_req), 64'd1);
    chk("wd_addr1", 64'(bus_addr), 64'h1000_0040);
    chk("wd_we", 64'(bus_we), 64'd1);
    tick();
    drive(4'b0000, 1'b1, 1'b0, '0);
    chk("wd_gnt", 64'(col_gnt), 64'b0010);
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    chk("wd_rv", 64'(col_rvalid), 64'b0010);
    tick();

    // Outstanding limit (rr_ptr now 2): two grants, then stall until a pop
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("lim_gnt2", 64'(col_gnt), 64'b0100);
    tick();
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("lim_gnt3", 64'(col_gnt), 64'b1000);
    tick();
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("lim_full_req", 64'(bus_req), 64'd0);
    chk("lim_full_gnt", 64'(col_gnt), 64'd0);
    chk("lim_full_addr", 64'(bus_addr), 64'd0);
    tick();
    drive(4'hF, 1'b1, 1'b1, 32'h77);
    chk("lim_pop_req", 64'(bus_req), 64'd0);
    chk("lim_pop_rv", 64'(col_rvalid), 64'b0100);
    tick();
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("lim_resume_req", 64'(bus_req), 64'd1);
    chk("lim_resume_gnt", 64'(col_gnt), 64'b0001);
    tick();

    // Reset mid-operation with two outstanding
    rst = 1'b1;
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("midrst_req", 64'(bus_req), 64'd0);
    tick();
    rst = 1'b0;
    drive(4'hF, 1'b1, 1'b0, '0);
    chk("midrst_gnt0", 64'(col_gnt), 64'b0001);
    tick();
    drive(4'h0, 1'b0, 1'b1, '0);
    chk("midrst_rv0", 64'(col_rvalid), 64'b0001);
    tick();

    // Spurious response with nothing outstanding
    drive(4'h0, 1'b0, 1'b1, 32'h99);
    chk("spur_rv", 64'(col_rvalid), 64'd0);
    chk("spur_err_pre", 64'(err), 64'd0);
    tick();
    drive(4'h0, 1'b0, 1'b0, '0);
    chk("spur_err", 64'(err), 64'd1);
    tick();
    chk("spur_err_sticky", 64'(err), 64'd1);
    drive(4'b0010, 1'b1, 1'b0, '0);
    chk("spur_still_gnt", 64'(col_gnt), 64'b0010);
    chk("spur_err_sticky2", 64'(err), 64'd1);
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, '0);
    chk("spur_err_in_rst", 64'(err), 64'd0);
    tick();
    rst = 1'b0;
    drive(4'h0, 1'b0, 1'b0, '0);
    chk("spur_err_cleared", 64'(err), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra_column_bus_arbiter.md
# cgra_column_bus_arbiter

Round-robin arbiter that merges the four CGRA column OBI master ports onto a single OBI master port toward the external crossbar. It serializes requests, keeps the selection locked while the downstream slave stalls, and records granted column indices in an in-order FIFO so that read/write responses route back to the originating column. It sits between the CGRA columns and the external crossbar master port. It frees crossbar master slots when the column count exceeds what the crossbar provides.

## Interface
- `N_COLS`, 4: number of column requesters (≥2).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enable is `DATA_W/8`.
- `MAX_OUTST`, 2: maximum outstanding transactions (response FIFO depth, ≥1).
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `col_req_i`  in  N_COLS  per-column request.
- `col_gnt_o`  out  N_COLS  per-column grant.
- `col_addr_i`  in  N_COLS*ADDR_W  per-column address; column i at slice i.
- `col_we_i`  in  N_COLS  write enable.
- `col_be_i`  in  N_COLS*DATA_W/8  byte enables.
- `col_wdata_i`  in  N_COLS*DATA_W  write data.
- `col_rvalid_o`  out  N_COLS  per-column response valid.
- `col_rdata_o`  out  DATA_W  response data, shared by all columns.
- `bus_req_o`, `bus_addr_o`, `bus_we_o`, `bus_be_o`, `bus_wdata_o`  out  1/ADDR_W/1/DATA_W/8/DATA_W  merged OBI request.
- `bus_gnt_i`  in  1  downstream grant.
- `bus_rvalid_i`  in  1  downstream response valid.
- `bus_rdata_i`  in  DATA_W  downstream read data.
- `err_o`  out  1  sticky protocol error: `bus_rvalid_i` arrived with an empty FIFO.

## Operation
- **State:** `rr_ptr` (highest-priority column), `locked` flag, `lock_idx`, response FIFO holding column indices, and `cnt`, the count of outstanding transactions (0..MAX_OUTST).
- **Selection:**
  - If `locked`, `sel = lock_idx`.
  - Otherwise `sel` is the first requesting column found scanning from `rr_ptr` upward, modulo N_COLS.
- **Issue:**
  - `bus_req_o` = (any `col_req_i`) AND (`cnt` < MAX_OUTST).
  - The bus payload is muxed from `sel`. When `bus_req_o` is 0, the payload is 0.
- **Handshake** (`bus_req_o` & `bus_gnt_i`):
  - `col_gnt_o[sel]` = 1 in that same cycle; all other column grants are 0.
  - Push `sel` into the FIFO.
  - Set `rr_ptr` to `(sel+1) mod N_COLS`.
  - Clear `locked`.
- **Lock:** if `bus_req_o` = 1 and `bus_gnt_i` = 0, set `locked` = 1 and `lock_idx = sel`. The downstream address and data stay stable until grant, as OBI requires. Newly arriving higher-priority requests are ignored while locked.
- **Response:**
  - On `bus_rvalid_i`, `col_rvalid_o[fifo_head]` = 1 and the FIFO head is popped.
  - `col_rdata_o` = `bus_rdata_i` unconditionally.
  - Writes also produce `rvalid`; the block does not distinguish reads from writes for routing.
- **Spurious response:** `bus_rvalid_i` with `cnt` = 0 sets `err_o`. No column `rvalid` is asserted and `cnt` stays at 0.
- **Push and pop in the same cycle:** `cnt` is unchanged. The FIFO stays correctly ordered, including when head and tail are the same slot with `cnt` = 1.
- **Full FIFO:** when `cnt` = MAX_OUTST, `bus_req_o` = 0 even if `bus_rvalid_i` = 1 in that cycle. There is no full-cycle bypass; issue resumes the cycle after the pop.
- **Column withdraws request:** a column dropping `col_req_i` while locked is a column protocol violation. The arbiter keeps `bus_req_o` asserted with the latched `sel` until grant. Because the drop makes the any-request condition false, the implementation must OR `locked` into the issue condition.

## Timing
- **Reset** (`rst_i` = 1 at a clock edge):
  - `rr_ptr` = 0, `locked` = 0, `cnt` = 0, FIFO pointers = 0, `err_o` = 0.
  - All outputs are 0 while `rst_i` is high.
  - Reset mid-transaction drops all outstanding tracking; responses arriving afterward set `err_o`.
- **Latency:** request to grant is combinational, 0 cycles, when unlocked and not full. Response routing is also combinational, 0 cycles.
- **Throughput:** with `bus_gnt_i` held high and responses returned each cycle, one transaction is issued per cycle.
- **Fairness:** with all columns continuously requesting, any column waits at most N_COLS−1 grants.

## Test plan
- **Single request:** column 2 requests address 0x2000_0040, `bus_gnt_i` = 1 → `col_gnt_o` = 0100 in the same cycle. `bus_rvalid_i` one cycle later with rdata 0xDEADBEEF → `col_rvalid_o` = 0100 and `col_rdata_o` = 0xDEADBEEF.
- **Round robin:** all 4 columns request continuously, gnt = 1, rvalid returned each following cycle → grant order 0,1,2,3,0. Each `rvalid` goes to the matching column in the same order.
- **Lock:** column 2 requests with gnt = 0 for 3 cycles; column 0 raises req in cycle 1 → `bus_addr_o` stays at column 2's address. Column 2 is granted in cycle 4 and column 0 in cycle 5.
- **Outstanding limit:** MAX_OUTST = 2, gnt = 1, rvalid withheld → two grants, then `bus_req_o` = 0. One rvalid → `bus_req_o` = 1 in the next cycle.
- **Spurious response:** `bus_rvalid_i` pulse with nothing outstanding → `err_o` = 1 and stays 1, all `col_rvalid_o` = 0. Asserting `rst_i` clears it.
- **Reset mid-operation:** two transactions outstanding, `rst_i` pulsed → `cnt` = 0 and `rr_ptr` = 0. The next 4-way request grants column 0 first.
